scope_trace_render: RTL and testbench

- Pixel stage directly downstream of the VGA timing generator in the oscilloscope design.
- Captures a triggered record of ADC samples into a double buffer: one column per sample, H_DISPLAY samples per record.
- Drives the RGB colour for each pixel from hpos/vpos: the trace, a graticule, or black.
- Re-times hsync, vsync and display_on through the same pipeline, so the colour and sync outputs reaching the connector stay aligned.

---
 rtl/scope_trace_render.sv | 206 ++++++++++++++++++++
 tb/tb_scope_trace_render.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_trace_render.sv
// scope_trace_render: captures a triggered ADC record into a double buffer and
// renders it, plus a graticule, as a 2-stage pixel pipeline behind the VGA timing.
module scope_trace_render #(
  parameter int unsigned HPOS_WIDTH   = 10,
  parameter int unsigned VPOS_WIDTH   = 10,
  parameter int unsigned H_DISPLAY    = 640,
  parameter int unsigned V_DISPLAY    = 480,
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned GRID_SHIFT   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic [SAMPLE_WIDTH-1:0] trig_level,
  input  logic [HPOS_WIDTH-1:0]   hpos,
  input  logic [VPOS_WIDTH-1:0]   vpos,
  input  logic                    display_on,
  input  logic                    hsync,
  input  logic                    vsync,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue,
  output logic                    hsync_o,
  output logic                    vsync_o,
  output logic                    display_on_o,
  output logic [1:0]              cap_state,
  output logic                    swapped
);

  localparam int unsigned AW         = $clog2(H_DISPLAY);
  localparam int unsigned RW         = VPOS_WIDTH + 1;
  localparam int unsigned HW1        = HPOS_WIDTH + 1;
  localparam int unsigned TRACE_BASE = V_DISPLAY / 2 + 2 ** (SAMPLE_WIDTH - 1) - 1;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_t;

  cap_state_t              r_state;
  logic                    r_front_sel;
  logic                    r_prev_valid;
  logic [SAMPLE_WIDTH-1:0] r_prev;
  logic [AW-1:0]           r_waddr;
  logic                    r_swapped;

  logic [SAMPLE_WIDTH-1:0] r_bank0 [H_DISPLAY];
  logic [SAMPLE_WIDTH-1:0] r_bank1 [H_DISPLAY];
  logic [SAMPLE_WIDTH-1:0] r_rd_sample;

  logic [GRID_SHIFT-1:0]   r_hgrid1;
  logic [VPOS_WIDTH-1:0]   r_vpos1;
  logic                    r_de1;
  logic                    r_hs1;
  logic                    r_vs1;

  logic [3:0]              r_red;
  logic [3:0]              r_green;
  logic [3:0]              r_blue;
  logic                    r_hs2;
  logic                    r_vs2;
  logic                    r_de2;

  logic                    w_trig;
  logic                    w_wr_en;
  logic [AW-1:0]           w_wr_addr;
  logic [AW-1:0]           w_rd_addr;
  logic                    w_vs_fall;
  logic [RW-1:0]           w_trace_row;
  logic                    w_on_trace;
  logic                    w_on_grid;
  logic [3:0]              w_red;
  logic [3:0]              w_green;
  logic [3:0]              w_blue;

  // Rising-edge trigger, back-bank write port and vsync fall detection
  assign w_trig    = r_prev_valid && (r_prev < trig_level) && (sample >= trig_level);
  assign w_wr_en   = sample_valid &&
                     (((r_state == ST_ARMED) && w_trig) || (r_state == ST_CAPTURE));
  assign w_wr_addr = (r_state == ST_CAPTURE) ? r_waddr : '0;
  assign w_vs_fall = r_vs1 && !vsync;
  assign w_rd_addr = (HW1'(hpos) < HW1'(H_DISPLAY)) ? AW'(hpos) : '0;

  // Capture FSM: arm, trigger, fill the back bank, swap on the next vsync fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_ARMED;
      r_front_sel  <= 1'b0;
      r_prev_valid <= 1'b0;
      r_prev       <= '0;
      r_waddr      <= '0;
      r_swapped    <= 1'b0;
    end else begin
      r_swapped <= 1'b0;
      case (r_state)
        ST_ARMED: begin
          if (sample_valid) begin
            r_prev       <= sample;
            r_prev_valid <= 1'b1;
            if (w_trig) begin
              r_waddr <= AW'(1);
              r_state <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (sample_valid) begin
            r_waddr <= r_waddr + AW'(1);
            if (r_waddr == AW'(H_DISPLAY - 1)) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (w_vs_fall) begin
            r_front_sel  <= ~r_front_sel;
            r_swapped    <= 1'b1;
            r_prev_valid <= 1'b0;
            r_waddr      <= '0;
            r_state      <= ST_ARMED;
          end
        end
        default: r_state <= ST_ARMED;
      endcase
    end
  end

  // Sample write into the back bank (the one not being displayed)
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (r_front_sel) r_bank0[w_wr_addr] <= sample;
      else             r_bank1[w_wr_addr] <= sample;
    end
  end

  // Stage 1 synchronous read of the front bank
  always_ff @(posedge clk) begin
    r_rd_sample <= r_front_sel ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];
  end

  // Stage 1 position and sync registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hgrid1 <= '0;
      r_vpos1  <= '0;
      r_de1    <= 1'b0;
      r_hs1    <= 1'b1;
      r_vs1    <= 1'b1;
    end else begin
      r_hgrid1 <= hpos[GRID_SHIFT-1:0];
      r_vpos1  <= vpos;
      r_de1    <= display_on;
      r_hs1    <= hsync;
      r_vs1    <= vsync;
    end
  end

  assign w_trace_row = RW'(TRACE_BASE) - RW'(r_rd_sample);
  assign w_on_trace  = (RW'(r_vpos1) == w_trace_row);
  assign w_on_grid   = (r_hgrid1 == '0) || (r_vpos1[GRID_SHIFT-1:0] == '0);

  // Colour select: blanking, then trace, then graticule
  always_comb begin
    w_red   = 4'h0;
    w_green = 4'h0;
    w_blue  = 4'h0;
    if (!r_de1) begin
      w_red   = 4'h0;
    end else if (w_on_trace) begin
      w_green = 4'hF;
    end else if (w_on_grid) begin
      w_red   = 4'h3;
      w_green = 4'h3;
      w_blue  = 4'h3;
    end
  end

  // Stage 2 output registers keep colour and sync aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_red   <= 4'h0;
      r_green <= 4'h0;
      r_blue  <= 4'h0;
      r_hs2   <= 1'b1;
      r_vs2   <= 1'b1;
      r_de2   <= 1'b0;
    end else begin
      r_red   <= w_red;
      r_green <= w_green;
      r_blue  <= w_blue;
      r_hs2   <= r_hs1;
      r_vs2   <= r_vs1;
      r_de2   <= r_de1;
    end
  end

  assign red          = r_red;
  assign green        = r_green;
  assign blue         = r_blue;
  assign hsync_o      = r_hs2;
  assign vsync_o      = r_vs2;
  assign display_on_o = r_de2;
  assign cap_state    = r_state;
  assign swapped      = r_swapped;

endmodule

// File: tb/tb_scope_trace_render.sv
// Self-checking bench for scope_trace_render: pixel scoreboard plus capture FSM checks.
module tb_scope_trace_render;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_valid;
  logic [7:0] sample;
  logic [7:0] trig_level;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       hsync;
  logic       vsync;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       hsync_o;
  logic       vsync_o;
  logic       display_on_o;
  logic [1:0] cap_state;
  logic       swapped;

  scope_trace_render dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .trig_level   (trig_level),
    .hpos         (hpos),
    .vpos         (vpos),
    .display_on   (display_on),
    .hsync        (hsync),
    .vsync        (vsync),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .display_on_o (display_on_o),
    .cap_state    (cap_state),
    .swapped      (swapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
    logic       de;
    bit         known;
  } exp_t;

  exp_t       sb_q[$];
  int         n_total = 0;
  int         n_bad   = 0;

  int         px_h;
  int         px_v;
  logic       px_de;
  logic       px_hs;
  logic       px_vs;
  logic       sv;
  logic [7:0] smp;
  bit         rnd_px;
  bit         rnd_vs;

  logic [7:0] m_bank [2][640];
  bit         m_known [2];
  int         m_front;
  logic [7:0] rec [640];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference pixel for inputs applied now, using the modelled front bank
  function automatic exp_t predict(input int h, input int v, input logic de,
                                   input logic hs, input logic vs);
    exp_t       e;
    logic [7:0] s;
    int         tr;
    e.hs    = hs;
    e.vs    = vs;
    e.de    = de;
    e.r     = 4'h0;
    e.g     = 4'h0;
    e.b     = 4'h0;
    e.known = !de || m_known[m_front];
    s       = m_bank[m_front][(h < 640) ? h : 0];
    tr      = 367 - int'(s);
    if (de) begin
      if (v == tr) e.g = 4'hF;
      else if ((h % 64 == 0) || (v % 64 == 0)) begin
        e.r = 4'h3;
        e.g = 4'h3;
        e.b = 4'h3;
      end
    end
    return e;
  endfunction

  // One clock: compare the pixel launched two cycles ago, then drive new inputs
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (sb_q.size() >= 2) begin
      e = sb_q.pop_front();
      check("hsync_o", 32'(hsync_o), 32'(e.hs));
      check("vsync_o", 32'(vsync_o), 32'(e.vs));
      check("display_on_o", 32'(display_on_o), 32'(e.de));
      if (e.known) begin
        check("red", 32'(red), 32'(e.r));
        check("green", 32'(green), 32'(e.g));
        check("blue", 32'(blue), 32'(e.b));
      end
    end
    if (rnd_px) begin
      px_h  = int'($urandom_range(0, 799));
      px_v  = int'($urandom_range(0, 524));
      px_de = 1'($urandom_range(0, 1));
      px_hs = 1'($urandom_range(0, 1));
    end
    if (rnd_vs) px_vs = 1'($urandom_range(0, 1));
    hpos         = 10'(px_h);
    vpos         = 10'(px_v);
    display_on   = px_de;
    hsync        = px_hs;
    vsync        = px_vs;
    sample_valid = sv;
    sample       = smp;
    sb_q.push_back(predict(px_h, px_v, px_de, px_hs, px_vs));
  endtask

  task automatic send(input logic [7:0] v);
    sv  = 1'b1;
    smp = v;
    cyc();
    sv  = 1'b0;
    cyc();
  endtask

  task automatic px(input int h, input int v, input logic de);
    rnd_px = 1'b0;
    px_h   = h;
    px_v   = v;
    px_de  = de;
    cyc();
  endtask

  // Produce a vsync fall while DONE and confirm the bank swap
  task automatic do_swap();
    px_vs = 1'b1;
    repeat (3) cyc();
    px_vs = 1'b0;
    cyc();
    for (int i = 0; i < 640; i++) m_bank[m_front ^ 1][i] = rec[i];
    m_known[m_front ^ 1] = 1'b1;
    m_front              = m_front ^ 1;
    cyc();
    check("swapped_pulse", 32'(swapped), 32'd1);
    check("cap_after_swap", 32'(cap_state), 32'd0);
    cyc();
    check("swapped_clear", 32'(swapped), 32'd0);
    px_vs = 1'b1;
  endtask

  // Trigger and capture a full record; optionally land the last write on a vsync fall
  task automatic run_record(input int kind, input bit coincide);
    rec[0] = 8'h80;
    for (int i = 1; i < 640; i++) rec[i] = (kind == 0) ? 8'(i * 3) : 8'(~i);
    if (kind == 0) rec[5] = 8'h00;
    px_vs = 1'b1;
    cyc();
    send(8'h10);
    check("arm_10", 32'(cap_state), 32'd0);
    send(8'h7F);
    check("arm_7f", 32'(cap_state), 32'd0);
    send(8'h80);
    check("trig_80", 32'(cap_state), 32'd1);
    for (int i = 1; i < 639; i++) send(rec[i]);
    check("cap_before_last", 32'(cap_state), 32'd1);
    if (coincide) begin
      sv    = 1'b1;
      smp   = rec[639];
      px_vs = 1'b0;
      cyc();
      sv = 1'b0;
      cyc();
      check("done_coinc", 32'(cap_state), 32'd2);
      check("no_swap_coinc", 32'(swapped), 32'd0);
      repeat (4) begin
        cyc();
        check("no_swap_hold", 32'(swapped), 32'd0);
      end
    end else begin
      send(rec[639]);
      check("done", 32'(cap_state), 32'd2);
    end
    repeat (3) send(8'hAA);
    check("done_hold", 32'(cap_state), 32'd2);
    do_swap();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_red"}, 32'(red), 32'd0);
    check({tag, "_green"}, 32'(green), 32'd0);
    check({tag, "_blue"}, 32'(blue), 32'd0);
    check({tag, "_hsync_o"}, 32'(hsync_o), 32'd1);
    check({tag, "_vsync_o"}, 32'(vsync_o), 32'd1);
    check({tag, "_de_o"}, 32'(display_on_o), 32'd0);
    check({tag, "_cap"}, 32'(cap_state), 32'd0);
    check({tag, "_swapped"}, 32'(swapped), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    sv           = 1'b0;
    smp          = 8'h00;
    sample_valid = 1'b0;
    sample       = 8'h00;
    trig_level   = 8'h80;
    px_h         = 0;
    px_v         = 0;
    px_de        = 1'b1;
    px_hs        = 1'b0;
    px_vs        = 1'b0;
    hpos         = 10'd0;
    vpos         = 10'd0;
    display_on   = 1'b1;
    hsync        = 1'b0;
    vsync        = 1'b0;
    rnd_px       = 1'b0;
    rnd_vs       = 1'b0;
    m_front      = 0;
    m_known[0]   = 1'b0;
    m_known[1]   = 1'b0;

    // Outputs hold reset values even with active inputs
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    sb_q.delete();

    // Sync alignment with random toggles; colour only known while blanked
    rnd_px = 1'b1;
    rnd_vs = 1'b1;
    repeat (200) cyc();
    rnd_vs = 1'b0;
    px_vs  = 1'b1;
    check("idle_armed", 32'(cap_state), 32'd0);

    // First sample after arming never triggers; 0x90,0x90 is no rising edge
    send(8'h90);
    check("first_no_trig", 32'(cap_state), 32'd0);
    send(8'h90);
    check("flat_no_trig", 32'(cap_state), 32'd0);

    run_record(0, 1'b1);

    // Directed render against the record now on screen
    px(5, 367, 1'b1);
    px(5, 366, 1'b1);
    px(64, 10, 1'b1);
    px(64, 10, 1'b0);
    px(0, 239, 1'b1);
    px(700, 239, 1'b1);
    px(639, 242, 1'b1);
    px(1, 364, 1'b1);
    px(128, 128, 1'b1);
    rnd_px = 1'b1;
    repeat (300) cyc();

    run_record(1, 1'b0);
    repeat (300) cyc();

    // Reset in the middle of a capture
    px_vs = 1'b1;
    send(8'h10);
    send(8'h80);
    check("cap3_trig", 32'(cap_state), 32'd1);
    repeat (100) send(8'h55);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midcap");
    sb_q.delete();
    m_front    = 0;
    m_known[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();

    // Front bank back to 0, still holding the second record
    repeat (300) cyc();
    send(8'h90);
    check("post_rst_first", 32'(cap_state), 32'd0);
    send(8'h10);
    send(8'h80);
    check("post_rst_trig", 32'(cap_state), 32'd1);
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
